// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button press classifier.
package btn_pkg;

  localparam int DEF_TICK_BITS  = 20;
  localparam int DEF_LONG_TICKS = 100;
  localparam int DEF_GAP_TICKS  = 30;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    GAP       = 3'd3,
    PRESS2    = 3'd4
  } btn_state_t;

  // Debug view of the classifier FSM for checkers and waveforms.
  typedef struct packed {
    btn_state_t state;
    logic [7:0] cnt;
  } btn_dbg_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for the one cycle the counter reads zero.
module tick_gen #(
  parameter int TICK_BITS = 20
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [TICK_BITS-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + TICK_BITS'(1);
  end

  assign tick = (count == '0);

endmodule

// File: rtl/btn_press_ctrl.sv
// Classifies a debounced button into short, long and double presses using a
// coarse tick; all event outputs are registered one-cycle pulses.
module btn_press_ctrl
  import btn_pkg::*;
#(
  parameter int TICK_BITS  = DEF_TICK_BITS,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     db,
  output logic     short_press,
  output logic     long_press,
  output logic     double_press,
  output logic     held,
  output logic     busy,
  output btn_dbg_t dbg
);

  localparam logic [7:0] LONG_LAST = 8'(LONG_TICKS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

  btn_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       db_prev;
  logic       rise, fall, tick;
  logic       short_nxt, long_nxt, double_nxt;

  tick_gen #(.TICK_BITS(TICK_BITS)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rise = db & ~db_prev;
  assign fall = ~db & db_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      db_prev      <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      db_prev      <= db;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
    end
  end

  // Edges are tested before tick in every state so an edge always wins.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == LONG_LAST) begin
            state_nxt = LONG_HOLD;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      LONG_HOLD: begin
        if (fall) state_nxt = IDLE;
      end
      GAP: begin
        if (rise) begin
          state_nxt = PRESS2;
        end else if (tick) begin
          if (cnt == GAP_LAST) begin
            state_nxt = IDLE;
            short_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      PRESS2: begin
        if (fall) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign held      = (state == LONG_HOLD);
  assign busy      = (state != IDLE);
  assign dbg.state = state;
  assign dbg.cnt   = cnt;

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Directed bench for btn_press_ctrl with a 16-cycle tick, 4-tick long press
// and 3-tick gap window; edge numbers count rising clocks since reset release.
module tb_btn_press_ctrl;
  import btn_pkg::*;

  logic     clk;
  logic     reset;
  logic     db;
  logic     short_press, long_press, double_press, held, busy;
  btn_dbg_t dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int n_short, n_long, n_double;
  int last_short, last_long, last_double;

  btn_press_ctrl #(
    .TICK_BITS  (4),
    .LONG_TICKS (4),
    .GAP_TICKS  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .busy         (busy),
    .dbg          (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) edge_n = 0;
    else       edge_n = edge_n + 1;
  end

  // pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (short_press)  begin n_short++;  last_short  = edge_n; end
      if (long_press)   begin n_long++;   last_long   = edge_n; end
      if (double_press) begin n_double++; last_double = edge_n; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_double = 0;
    last_short = -1; last_long = -1; last_double = -1;
  endtask

  task automatic do_reset(input logic db_val);
    reset = 1'b1;
    db    = db_val;
    repeat (3) @(posedge clk);
    #1;
    clear_counts();
    reset = 1'b0;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    db    = 1'b0;
    clear_counts();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {11'd0, short_press, long_press, double_press, held, busy}, 16'd0);
    check("rst_state", dbg.state, IDLE);
    check("rst_cnt", dbg.cnt, 8'd0);

    // short press: rise@3, fall@23, gap ticks @33,@49,@65 -> short at 65
    do_reset(1'b0);
    run_to(2);  db = 1'b1;
    run_to(3);
    check("sp_state_press1", dbg.state, PRESS1);
    check("sp_busy", busy, 1'b1);
    run_to(22); db = 1'b0;
    run_to(23);
    check("sp_state_gap", dbg.state, GAP);
    check("sp_gap_cnt", dbg.cnt, 8'd0);
    run_to(64);
    check("sp_early", short_press, 1'b0);
    run_to(65);
    check("sp_pulse", short_press, 1'b1);
    run_to(66);
    check("sp_pulse_width", short_press, 1'b0);
    run_to(102);
    check("sp_n_short", n_short, 16'd1);
    check("sp_at", last_short, 16'd65);
    check("sp_n_long", n_long, 16'd0);
    check("sp_n_double", n_double, 16'd0);
    check("sp_idle", busy, 1'b0);

    // long press: ticks @17,@33,@49,@65 -> long at 65, release @103
    do_reset(1'b0);
    run_to(2);  db = 1'b1;
    run_to(64);
    check("lp_cnt_last", dbg.cnt, 8'd3);
    check("lp_early", long_press, 1'b0);
    run_to(65);
    check("lp_pulse", long_press, 1'b1);
    check("lp_held_on", held, 1'b1);
    run_to(80);
    check("lp_held_mid", held, 1'b1);
    check("lp_pulse_gone", long_press, 1'b0);
    run_to(102); db = 1'b0;
    run_to(103);
    check("lp_held_off", held, 1'b0);
    check("lp_busy_off", busy, 1'b0);
    run_to(130);
    check("lp_n_long", n_long, 16'd1);
    check("lp_at", last_long, 16'd65);
    check("lp_n_short", n_short, 16'd0);

    // double press: fall@23, rise@43, fall@63 -> double at 63
    do_reset(1'b0);
    run_to(2);  db = 1'b1;
    run_to(22); db = 1'b0;
    run_to(42);
    check("dp_gap_cnt", dbg.cnt, 8'd1);
    db = 1'b1;
    run_to(43);
    check("dp_state_press2", dbg.state, PRESS2);
    run_to(62); db = 1'b0;
    run_to(63);
    check("dp_pulse", double_press, 1'b1);
    run_to(130);
    check("dp_n_double", n_double, 16'd1);
    check("dp_at", last_double, 16'd63);
    check("dp_n_short", n_short, 16'd0);
    check("dp_n_long", n_long, 16'd0);

    // rise coincident with the tick at edge 49 while in GAP
    do_reset(1'b0);
    run_to(2);  db = 1'b1;
    run_to(22); db = 1'b0;
    run_to(48);
    check("rt_state_gap", dbg.state, GAP);
    check("rt_cnt_before", dbg.cnt, 8'd1);
    db = 1'b1;
    run_to(49);
    check("rt_state_press2", dbg.state, PRESS2);
    check("rt_cnt_kept", dbg.cnt, 8'd1);
    run_to(52); db = 1'b0;
    run_to(53);
    check("rt_double", double_press, 1'b1);
    run_to(120);
    check("rt_n_double", n_double, 16'd1);
    check("rt_n_short", n_short, 16'd0);

    // reset during PRESS1 after two ticks
    do_reset(1'b0);
    run_to(2);  db = 1'b1;
    run_to(40);
    check("ra_cnt", dbg.cnt, 8'd2);
    reset = 1'b1;
    #1;
    check("ra_outputs", {11'd0, short_press, long_press, double_press, held, busy}, 16'd0);
    check("ra_state", dbg.state, IDLE);
    db = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_counts();
    reset = 1'b0;
    run_to(100);
    check("ra_no_pulse", n_short + n_long + n_double, 16'd0);
    check("ra_busy", busy, 1'b0);

    // button already pressed at reset release
    do_reset(1'b1);
    run_to(1);
    check("rp_busy", busy, 1'b1);
    check("rp_state", dbg.state, PRESS1);
    check("rp_cnt", dbg.cnt, 8'd0);
    run_to(64);
    check("rp_early", long_press, 1'b0);
    run_to(65);
    check("rp_long", long_press, 1'b1);
    db = 1'b0;
    run_to(70);
    check("rp_released", busy, 1'b0);
    check("rp_n_long", n_long, 16'd1);
    check("rp_n_short", n_short, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
